carry_resolver: RTL

//   Consumes the bitwise (sum, carry) vector pair produced by the ALU's

---
 rtl/carry_resolver_pkg.sv | 25 ++
 rtl/carry_resolver.sv | 121 ++++++++++++
 2 files changed

// File: rtl/carry_resolver_pkg.sv
// rtl/carry_resolver_pkg.sv - shared state encoding and width defaults for carry_resolver
//
// Purpose:
//   Holds the FSM state encoding and the default data width used by the
//   carry_resolver block and by anything that instantiates or drives it.
// Contents:
//   CR_W_DEFAULT   default data width of sum/carry/result
//   cr_state_t     2-bit FSM state encoding (IDLE, RESOLVE, DONE)
//   cr_iter_width  width needed to count 0..w ripple steps

package carry_resolver_pkg;

   localparam int CR_W_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RESOLVE = 2'b01,
      ST_DONE    = 2'b10
   } cr_state_t;

   function automatic int cr_iter_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/carry_resolver.sv
// rtl/carry_resolver.sv - iterative resolver of a (sum, carry) pair into sum + (carry<<1)
//
// Purpose:
//   Takes the bitwise half-add outputs (sum = a^b, carry = a&b) and ripples
//   the carries one step per clock until none remain, yielding a+b mod 2^W
//   plus the carry-out. No wide adder is used.
// Ports:
//   clk         in   1    clock, rising edge
//   rst_n       in   1    asynchronous active-low reset
//   in_valid    in   1    in_sum/in_carry valid
//   in_ready    out  1    high only in IDLE
//   in_sum      in   W    bitwise XOR vector
//   in_carry    in   W    bitwise AND vector, unshifted
//   out_valid   out  1    high only in DONE
//   out_ready   in   1    downstream accepts the result
//   out_result  out  W    (in_sum + (in_carry<<1)) mod 2^W
//   out_cout    out  1    bit W of the full sum
//   out_iters   out  ITW  ripple steps taken, 0..W

module carry_resolver
   import carry_resolver_pkg::*;
#(
   parameter  int W   = CR_W_DEFAULT,
   localparam int ITW = cr_iter_width(W)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_sum,
   input  logic [W-1:0]   in_carry,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_result,
   output logic           out_cout,
   output logic [ITW-1:0] out_iters
);

   cr_state_t      state;
   cr_state_t      state_nxt;
   logic [W-1:0]   s;
   logic [W-1:0]   s_nxt;
   logic [W-1:0]   c;
   logic [W-1:0]   c_nxt;
   logic           cout;
   logic           cout_nxt;
   logic [ITW-1:0] iters;
   logic [ITW-1:0] iters_nxt;

   // Carry vector aligned to the bit it feeds; c[W-1] falls off the top and
   // is accounted for only in cout.
   logic [W-1:0]   c_sh;
   assign c_sh = {c[W-2:0], 1'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         s     <= '0;
         c     <= '0;
         cout  <= 1'b0;
         iters <= '0;
      end else begin
         state <= state_nxt;
         s     <= s_nxt;
         c     <= c_nxt;
         cout  <= cout_nxt;
         iters <= iters_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      s_nxt     = s;
      c_nxt     = c;
      cout_nxt  = cout;
      iters_nxt = iters;
      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               s_nxt     = in_sum;
               c_nxt     = in_carry;
               cout_nxt  = 1'b0;
               iters_nxt = '0;
               state_nxt = ST_RESOLVE;
            end
         end
         ST_RESOLVE: begin
            // Finishing costs one extra edge even when the input had no
            // carries, so latency is always iters+1.
            if (c == '0) begin
               state_nxt = ST_DONE;
            end else begin
               cout_nxt  = cout | c[W-1];
               s_nxt     = s ^ c_sh;
               c_nxt     = s & c_sh;
               iters_nxt = iters + ITW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign in_ready   = (state == ST_IDLE);
   assign out_valid  = (state == ST_DONE);
   assign out_result = s;
   assign out_cout   = cout;
   assign out_iters  = iters;

   // The lowest set carry bit moves up by at least one position per step,
   // so a live carry can never remain once W steps have been taken.
   a_iters_bound : assert property (@(posedge clk) disable iff (!rst_n)
      (state == ST_RESOLVE && c != '0) |-> (iters < ITW'(W)));

endmodule
